// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, FSM state type and result packing for fp_norm
//
// Purpose : common definitions for the post-add normaliser and its rounding helper.
// Contents: field widths, exponent bias/limit, FSM state enum, packed result layout
//           {sign, exp[4:0], frac[4:0]} (hidden 1 not stored) and a packing helper.

package fp_pkg;

   localparam int EXP_W   = 5;
   localparam int MANT_W  = 6;                 // hidden 1 + fraction
   localparam int FRAC_W  = MANT_W - 1;
   localparam int BIAS    = 15;
   localparam int EXP_MAX = 2 * BIAS + 1;      // 31, all-ones exponent
   localparam int RES_W   = 1 + EXP_W + FRAC_W;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_result_t;

   function automatic fp_result_t pack_result(input logic              sign,
                                              input logic [EXP_W-1:0]  exp,
                                              input logic [FRAC_W-1:0] frac);
      fp_result_t r;
      r.sign = sign;
      r.exp  = exp;
      r.frac = frac;
      return r;
   endfunction

endpackage

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - round-to-nearest-even right shift by one for fp_norm
//
// Purpose : present only when FP_NORM_ROUND_EN is defined. Takes the 7-bit
//           magnitude whose bit 6 is set, shifts it right one place with
//           round-to-nearest-even, and renormalises if rounding carries to 64.
// Ports   : mag_in   [6:0] magnitude before the shift
//           exp_in   [4:0] exponent before the shift
//           frac_out [4:0] fraction after shift/round (hidden 1 dropped)
//           exp_out  [5:0] exponent after shift/round, one extra bit so the
//                          caller can detect overflow

`ifdef FP_NORM_ROUND_EN
module fp_norm_round
   import fp_pkg::*;
(
   input  logic [MANT_W:0]   mag_in,
   input  logic [EXP_W-1:0]  exp_in,
   output logic [FRAC_W-1:0] frac_out,
   output logic [EXP_W:0]    exp_out
);

   logic [MANT_W-1:0] kept;
   logic              inc;
   logic [MANT_W:0]   sum;

   always_comb begin
      kept = mag_in[MANT_W:1];
      // Only one bit is dropped, so a set dropped bit is always an exact tie:
      // round up only when that makes the kept value even.
      inc  = mag_in[0] & kept[0];
      sum  = {1'b0, kept} + {{MANT_W{1'b0}}, inc};
      if (sum[MANT_W]) begin
         // 63 rounded up to 64: shift right once more, exponent +2 in total
         frac_out = sum[FRAC_W:1];
         exp_out  = {1'b0, exp_in} + 6'd2;
      end else begin
         frac_out = sum[FRAC_W-1:0];
         exp_out  = {1'b0, exp_in} + 6'd1;
      end
   end

endmodule
`endif

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - normalise a signed mantissa-adder sum into a small FP result
//
// Purpose : accepts the raw two's-complement sum of a mantissa add together with
//           the larger operand's exponent and sign, normalises it (one right
//           shift or up to five left shifts) and returns {sign, exp, frac} with
//           overflow / underflow / zero status.
// Config  : FP_NORM_ROUND_EN - when defined, the right shift rounds to
//           nearest-even via fp_norm_round; otherwise it truncates.
// Ports   : clk, rst (synchronous, active-high)
//           in_valid/in_ready     - operand handshake (ready only in IDLE)
//           raw_sum[7:0]          - signed sum from the mantissa adder
//           exp_in[4:0], sign_in  - exponent (bias 15) and sign of larger operand
//           out_valid/out_ready   - result handshake; result held until taken
//           result[10:0]          - {sign, exp[4:0], frac[4:0]}, hidden 1
//           ovf, unf, zero        - mutually exclusive flags, valid with out_valid

module fp_norm
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       raw_sum,
   input  logic [EXP_W-1:0] exp_in,
   input  logic             sign_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] result,
   output logic             ovf,
   output logic             unf,
   output logic             zero
);

   state_t           state_q, state_d;
   logic             mag_vld_q, mag_vld_d;
   logic [7:0]       sum_q, sum_d;
   logic [MANT_W:0]  mag_q, mag_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic             sign_q, sign_d;
   fp_result_t       res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             zero_q, zero_d;

   logic [FRAC_W-1:0] shr_frac;
   logic [EXP_W:0]    shr_exp;
   logic [MANT_W:0]   mag_shl;
   logic [EXP_W-1:0]  exp_dec;

`ifdef FP_NORM_ROUND_EN
   fp_norm_round u_round (
      .mag_in   (mag_q),
      .exp_in   (exp_q),
      .frac_out (shr_frac),
      .exp_out  (shr_exp)
   );
`else
   assign shr_frac = mag_q[FRAC_W:1];
   assign shr_exp  = {1'b0, exp_q} + 6'd1;
`endif

   always_comb begin
      state_d   = state_q;
      mag_vld_d = mag_vld_q;
      sum_d     = sum_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      sign_d    = sign_q;
      res_d     = res_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      zero_d    = zero_q;
      mag_shl   = {mag_q[MANT_W-1:0], 1'b0};
      exp_dec   = exp_q - 5'd1;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sum_d     = raw_sum;
               exp_d     = exp_in;
               sign_d    = sign_in;
               mag_vld_d = 1'b0;
               state_d   = ALIGN;
            end
         end

         ALIGN: begin
            // First ALIGN cycle only registers the magnitude, so the negate
            // adder never chains into the round/exponent adders.
            if (!mag_vld_q) begin
               mag_d     = sum_q[7] ? (~sum_q[MANT_W:0] + 7'd1) : sum_q[MANT_W:0];
               sign_d    = sign_q ^ sum_q[7];
               mag_vld_d = 1'b1;
            end else begin
               mag_vld_d = 1'b0;
               state_d   = DONE;
               if (mag_q == '0) begin
                  res_d  = '0;
                  zero_d = 1'b1;
               end else if (mag_q[MANT_W]) begin
                  if (shr_exp >= 6'(EXP_MAX)) begin
                     res_d = pack_result(sign_q, 5'h1F, '0);
                     ovf_d = 1'b1;
                  end else begin
                     res_d = pack_result(sign_q, shr_exp[EXP_W-1:0], shr_frac);
                  end
               end else if (mag_q[MANT_W-1]) begin
                  res_d = pack_result(sign_q, exp_q, mag_q[FRAC_W-1:0]);
               end else if (exp_q == '0) begin
                  // No exponent left to trade for a left shift
                  res_d = pack_result(sign_q, '0, mag_q[FRAC_W-1:0]);
                  unf_d = 1'b1;
               end else begin
                  state_d = NORM;
               end
            end
         end

         NORM: begin
            mag_d = mag_shl;
            exp_d = exp_dec;
            // Hitting exponent 0 wins over reaching the hidden bit: exp 0
            // encodes a denormal in this format.
            if (exp_dec == '0) begin
               res_d   = pack_result(sign_q, '0, mag_shl[FRAC_W-1:0]);
               unf_d   = 1'b1;
               state_d = DONE;
            end else if (mag_shl[MANT_W-1]) begin
               res_d   = pack_result(sign_q, exp_dec, mag_shl[FRAC_W-1:0]);
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               zero_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mag_vld_q <= 1'b0;
         sum_q     <= '0;
         mag_q     <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mag_vld_q <= mag_vld_d;
         sum_q     <= sum_d;
         mag_q     <= mag_d;
         exp_q     <= exp_d;
         sign_q    <= sign_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         zero_q    <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_fp_norm.sv
// tb/tb_fp_norm.sv - directed self-checking bench for fp_norm

module tb_fp_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  raw_sum;
   logic [4:0]  exp_in;
   logic        sign_in;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] result;
   logic        ovf;
   logic        unf;
   logic        zero;

   int n_vec  = 0;
   int n_miss = 0;

`ifdef FP_NORM_ROUND_EN
   localparam logic [10:0] RES_75  = 11'h166;
   localparam logic [10:0] RES_127 = 11'h3E0;
   localparam logic [2:0]  FL_127  = 3'b100;
`else
   localparam logic [10:0] RES_75  = 11'h165;
   localparam logic [10:0] RES_127 = 11'h3DF;
   localparam logic [2:0]  FL_127  = 3'b000;
`endif

   always #5 clk = ~clk;

   fp_norm dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .raw_sum   (raw_sum),
      .exp_in    (exp_in),
      .sign_in   (sign_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf),
      .zero      (zero)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic start_op(input logic [7:0] raw, input logic [4:0] e, input logic s);
      @(negedge clk);
      in_valid = 1'b1;
      raw_sum  = raw;
      exp_in   = e;
      sign_in  = s;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      raw_sum  = 8'h00;
      exp_in   = 5'h00;
      sign_in  = 1'b0;
   endtask

   // flags are {ovf, unf, zero}; latency counts rising edges after the accept edge
   task automatic apply(input string tag, input logic [7:0] raw, input logic [4:0] e,
                        input logic s, input logic [10:0] want_res, input logic [2:0] want_fl,
                        input int want_lat, input int hold);
      int lat;
      @(negedge clk);
      check_eq({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
      start_op(raw, e, s);
      check_eq({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_eq({tag, "/latency"}, 32'(lat), 32'(want_lat));
      check_eq({tag, "/result"}, 32'(result), 32'(want_res));
      check_eq({tag, "/flags"}, 32'({ovf, unf, zero}), 32'(want_fl));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "/hold_result"}, 32'(result), 32'(want_res));
         check_eq({tag, "/hold_flags"}, 32'({ovf, unf, zero}), 32'(want_fl));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "/valid_after"}, 32'(out_valid), 32'd0);
      check_eq({tag, "/flags_after"}, 32'({ovf, unf, zero}), 32'd0);
      check_eq({tag, "/ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      int   wait_cnt;

      rst       = 1'b1;
      in_valid  = 1'b0;
      raw_sum   = 8'h00;
      exp_in    = 5'h00;
      sign_in   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset/in_ready", 32'(in_ready), 32'd1);
      check_eq("reset/out_valid", 32'(out_valid), 32'd0);
      check_eq("reset/result", 32'(result), 32'd0);
      check_eq("reset/flags", 32'({ovf, unf, zero}), 32'd0);
      rst = 1'b0;

      apply("right_shift",   8'd72,  5'd10, 1'b0, 11'h164, 3'b000, 2, 0);
      apply("norm3_hold",    8'd5,   5'd10, 1'b0, 11'h0E8, 3'b000, 5, 10);
      apply("negative",      8'hD8,  5'd12, 1'b0, 11'h588, 3'b000, 2, 0);
      apply("zero",          8'h00,  5'd12, 1'b1, 11'h000, 3'b001, 2, 0);
      apply("ovf_exp31",     8'd100, 5'd31, 1'b0, 11'h3E0, 3'b100, 2, 0);
      apply("unf_denorm",    8'd3,   5'd2,  1'b0, 11'h00C, 3'b010, 4, 0);
      apply("round_75",      8'd75,  5'd10, 1'b0, RES_75,  3'b000, 2, 0);
      apply("no_shift",      8'd40,  5'd20, 1'b1, 11'h688, 3'b000, 2, 0);
      apply("norm5_max",     8'd1,   5'd20, 1'b0, 11'h1E0, 3'b000, 7, 0);
      apply("neg_norm4",     8'hFD,  5'd10, 1'b0, 11'h4D0, 3'b000, 6, 0);
      apply("ovf_exp30",     8'd64,  5'd30, 1'b1, 11'h7E0, 3'b100, 2, 0);
      apply("round_carry",   8'd127, 5'd29, 1'b0, RES_127, FL_127, 2, 0);

      // reset in the middle of NORM: operation discarded
      start_op(8'd5, 5'd10, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_norm/in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_norm/out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_norm/result", 32'(result), 32'd0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check_eq("abort_norm/no_valid", 32'(seen), 32'd0);

      // reset while holding a result in DONE
      start_op(8'd100, 5'd31, 1'b0);
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check_eq("abort_done/reached", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_done/out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_done/result", 32'(result), 32'd0);
      check_eq("abort_done/flags", 32'({ovf, unf, zero}), 32'd0);
      check_eq("abort_done/in_ready", 32'(in_ready), 32'd1);

      apply("after_abort",   8'd72,  5'd10, 1'b0, 11'h164, 3'b000, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
